dest_reg_scoreboard: RTL and testbench

//  Tracks in-flight register writes for the DLX pipeline. It consumes the 5-bit

---
 rtl/dest_reg_scoreboard_if.sv | 32 +++
 rtl/dest_reg_scoreboard.sv | 99 +++++++++
 tb/tb_dest_reg_scoreboard.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/dest_reg_scoreboard_if.sv
// Decode/write-back handshake bundle for the destination-register scoreboard.
`timescale 1ns/1ps
interface dest_reg_scoreboard_if;
   logic        issue_valid;
   logic        issue_we;
   logic [4:0]  issue_rd;
   logic [4:0]  src1;
   logic        src1_use;
   logic [4:0]  src2;
   logic        src2_use;
   logic        wb_valid;
   logic [4:0]  wb_rd;
   logic        flush;
   logic        stall;
   logic [31:0] busy;
   logic [5:0]  inflight;
   logic        err;

   // Pipeline side: drives issue/retire/flush, observes scoreboard state.
   modport master (
      output issue_valid, issue_we, issue_rd, src1, src1_use, src2, src2_use,
      output wb_valid, wb_rd, flush,
      input  stall, busy, inflight, err
   );

   // Scoreboard side.
   modport slave (
      input  issue_valid, issue_we, issue_rd, src1, src1_use, src2, src2_use,
      input  wb_valid, wb_rd, flush,
      output stall, busy, inflight, err
   );
endinterface

// File: rtl/dest_reg_scoreboard.sv
// Destination-register scoreboard: per-register pending-write counters, decode
// stall on RAW hazards or counter saturation, sticky error on bogus retires.
`timescale 1ns/1ps
module dest_reg_scoreboard #(
   parameter int unsigned CNT_W = 2,
   parameter int unsigned NREG  = 32
) (
   input logic                  clk,
   input logic                  reset,
   dest_reg_scoreboard_if.slave sb
);

   localparam logic [CNT_W-1:0] CntMax = '1;

   logic [CNT_W-1:0] cnt_q [NREG];
   logic [CNT_W-1:0] cnt_d [NREG];
   logic [5:0]       inflight_q, inflight_d;
   logic             err_q, err_d;
   logic [31:0]      busy;
   logic             stall;
   logic             accept;

   // Busy vector straight from registered counters.
   always_comb begin
      busy = '0;
      for (int unsigned i = 0; i < NREG; i++) begin
         busy[i] = (cnt_q[i] != '0);
      end
   end

   // Stall uses registered state only; a same-cycle retire does not release it.
   always_comb begin
      stall  = sb.issue_valid &
               ((sb.src1_use & busy[sb.src1]) |
                (sb.src2_use & busy[sb.src2]) |
                (sb.issue_we & (sb.issue_rd != 5'd0) & (cnt_q[sb.issue_rd] == CntMax)));
      accept = sb.issue_valid & ~stall & ~sb.flush;
   end

   // Counter, error and in-flight total next state; flush wins over issue/retire.
   always_comb begin
      int unsigned sum;
      logic        inc;
      logic        dec;
      err_d = err_q;
      sum   = 0;
      inc   = 1'b0;
      dec   = 1'b0;
      for (int unsigned i = 0; i < NREG; i++) begin
         cnt_d[i] = cnt_q[i];
      end
      if (sb.flush) begin
         for (int unsigned i = 0; i < NREG; i++) begin
            cnt_d[i] = '0;
         end
      end else begin
         // r0 is never tracked, so its counter is left at zero.
         for (int unsigned i = 1; i < NREG; i++) begin
            inc = accept & sb.issue_we & (sb.issue_rd == 5'(i));
            dec = sb.wb_valid & (sb.wb_rd == 5'(i)) & (cnt_q[i] != '0);
            if (inc && !dec) begin
               cnt_d[i] = cnt_q[i] + 1'b1;
            end else if (dec && !inc) begin
               cnt_d[i] = cnt_q[i] - 1'b1;
            end
         end
         if (sb.wb_valid && (sb.wb_rd != 5'd0) && (cnt_q[sb.wb_rd] == '0)) begin
            err_d = 1'b1;
         end
      end
      for (int unsigned i = 1; i < NREG; i++) begin
         sum = sum + 32'(cnt_d[i]);
      end
      inflight_d = 6'(sum);
   end

   // State registers with asynchronous reset.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int unsigned i = 0; i < NREG; i++) begin
            cnt_q[i] <= '0;
         end
         inflight_q <= '0;
         err_q      <= 1'b0;
      end else begin
         for (int unsigned i = 0; i < NREG; i++) begin
            cnt_q[i] <= cnt_d[i];
         end
         inflight_q <= inflight_d;
         err_q      <= err_d;
      end
   end

   assign sb.stall    = stall;
   assign sb.busy     = busy;
   assign sb.inflight = inflight_q;
   assign sb.err      = err_q;

endmodule

// File: tb/tb_dest_reg_scoreboard.sv
// Self-checking bench: driver pushes expected per-cycle state from a reference
// model into a queue; a negedge monitor pops and compares against the DUT.
`timescale 1ns/1ps
module tb_dest_reg_scoreboard;

   typedef struct {
      logic        stall;
      logic [31:0] busy;
      logic [5:0]  inflight;
      logic        err;
   } exp_t;

   logic clk;
   logic reset;
   dest_reg_scoreboard_if sb_if ();

   dest_reg_scoreboard #(.CNT_W(2), .NREG(32)) dut (
      .clk   (clk),
      .reset (reset),
      .sb    (sb_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   exp_t q[$];
   int   cnt_m [32];
   bit   err_m;
   int   n_checks = 0;
   int   n_pass   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
   endtask

   function automatic exp_t model_now(input bit iv, we, input int rd, s1, input bit u1,
                                      input int s2, input bit u2);
      exp_t e;
      int   sum = 0;
      e.busy = '0;
      for (int i = 1; i < 32; i++) begin
         e.busy[i] = (cnt_m[i] > 0);
         sum += cnt_m[i];
      end
      e.inflight = 6'(sum % 64);
      e.err      = err_m;
      e.stall    = iv && ((u1 && cnt_m[s1] > 0) || (u2 && cnt_m[s2] > 0) ||
                          (we && rd != 0 && cnt_m[rd] == 3));
      return e;
   endfunction

   function automatic void model_clear();
      for (int i = 0; i < 32; i++) cnt_m[i] = 0;
   endfunction

   task automatic idle_inputs();
      sb_if.issue_valid = 0; sb_if.issue_we = 0; sb_if.issue_rd = 0;
      sb_if.src1 = 0; sb_if.src1_use = 0; sb_if.src2 = 0; sb_if.src2_use = 0;
      sb_if.wb_valid = 0; sb_if.wb_rd = 0; sb_if.flush = 0;
   endtask

   // One clock cycle of stimulus; expected values for this cycle go to the queue.
   task automatic step(input bit iv, we, input int rd, s1, input bit u1, input int s2,
                       input bit u2, input bit wv, input int wr, input bit fl);
      exp_t e;
      @(posedge clk);
      #1;
      sb_if.issue_valid = iv; sb_if.issue_we = we; sb_if.issue_rd = 5'(rd);
      sb_if.src1 = 5'(s1); sb_if.src1_use = u1; sb_if.src2 = 5'(s2); sb_if.src2_use = u2;
      sb_if.wb_valid = wv; sb_if.wb_rd = 5'(wr); sb_if.flush = fl;
      e = model_now(iv, we, rd, s1, u1, s2, u2);
      q.push_back(e);
      if (fl) begin
         model_clear();
      end else begin
         if (wv && wr != 0) begin
            if (cnt_m[wr] == 0) err_m = 1;
            else cnt_m[wr]--;
         end
         if (iv && !e.stall && we && rd != 0) cnt_m[rd]++;
      end
   endtask

   task automatic issue(input int rd);
      step(1, 1, rd, 0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic retire(input int wr);
      step(0, 0, 0, 0, 0, 0, 0, 1, wr, 0);
   endtask

   // Asynchronous reset pulse in the middle of a cycle.
   task automatic mid_reset();
      exp_t e;
      @(posedge clk);
      #1;
      idle_inputs();
      reset = 1;
      model_clear();
      err_m = 0;
      #1;
      check("reset_busy", sb_if.busy, 0);
      check("reset_inflight", 32'(sb_if.inflight), 0);
      check("reset_err", 32'(sb_if.err), 0);
      check("reset_stall", 32'(sb_if.stall), 0);
      #1;
      reset = 0;
      e = model_now(0, 0, 0, 0, 0, 0, 0);
      q.push_back(e);
   endtask

   // Monitor: every cycle with a queued expectation is compared mid-cycle.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (q.size() > 0) begin
            e = q.pop_front();
            check("stall", 32'(sb_if.stall), 32'(e.stall));
            check("busy", sb_if.busy, e.busy);
            check("inflight", 32'(sb_if.inflight), 32'(e.inflight));
            check("err", 32'(sb_if.err), 32'(e.err));
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      int iv, we, rd, s1, u1, s2, u2, wv, wr, fl, w;
      idle_inputs();
      model_clear();
      err_m = 0;
      reset = 1;
      repeat (2) @(posedge clk);
      #1;
      reset = 0;

      // 1: build cnt[5]=2, then reset mid-run
      issue(5);
      issue(5);
      mid_reset();

      // 2: RAW hazard on r5, released one cycle after retire
      issue(5);
      step(1, 0, 0, 5, 1, 0, 0, 0, 0, 0);
      step(1, 0, 0, 5, 1, 0, 0, 1, 5, 0);
      step(1, 0, 0, 5, 1, 0, 0, 0, 0, 0);

      // 3: r0 never tracked or stalls
      step(1, 1, 0, 0, 1, 0, 1, 0, 0, 0);
      step(1, 0, 0, 0, 1, 0, 1, 0, 0, 0);

      // 4: accept and retire same register in one cycle
      issue(7);
      step(1, 1, 7, 0, 0, 0, 0, 1, 7, 0);
      retire(7);

      // 5: saturate r9, fourth issue stalls
      issue(9); issue(9); issue(9);
      issue(9);
      step(1, 1, 9, 0, 0, 0, 0, 0, 0, 0);
      retire(9); retire(9); retire(9);

      // 6: spurious retire sets err; flush clears counters but keeps err
      retire(12);
      issue(3); issue(3);
      step(1, 1, 4, 0, 0, 0, 0, 1, 3, 1);
      step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

      // Randomized traffic on a small register window to provoke hazards
      mid_reset();
      for (int n = 0; n < 1500; n++) begin
         if (n == 700) mid_reset();
         iv = ($urandom_range(0, 3) != 0);
         we = ($urandom_range(0, 3) != 0);
         rd = $urandom_range(0, 7);
         s1 = $urandom_range(0, 7);
         u1 = $urandom_range(0, 1);
         s2 = $urandom_range(0, 7);
         u2 = $urandom_range(0, 1);
         wr = $urandom_range(0, 7);
         wv = $urandom_range(0, 1);
         if (wv != 0 && cnt_m[wr] == 0 && $urandom_range(0, 19) != 0) wv = 0;
         fl = ($urandom_range(0, 59) == 0);
         step(iv[0], we[0], rd, s1, u1[0], s2, u2[0], wv[0], wr, fl[0]);
      end

      @(posedge clk);
      #1;
      idle_inputs();
      w = 0;
      while (q.size() != 0 && w < 10) begin
         @(posedge clk);
         w++;
      end
      check("queue_drain", 32'(q.size()), 0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
